// File: rtl/fpga_cfg_pkg.sv
// Shared types and default geometry for the fabric configuration controller,
// the fabric model and their benches.
package fpga_cfg_pkg;

    localparam int unsigned DEF_CFG_HEIGHT = 32;
    localparam int unsigned DEF_CFG_LENGTH = 64;

    typedef enum logic [1:0] {
        CFG_IDLE  = 2'd0,
        CFG_WAIT  = 2'd1,
        CFG_LOAD  = 2'd2,
        CFG_FLUSH = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/fabric_cfg_ctrl_if.sv
// Bitstream stream, fabric chain, status and PCPI gating signals of the
// configuration controller; master is the host/CPU side, slave the controller.
interface fabric_cfg_ctrl_if #(
    parameter int unsigned CFG_HEIGHT = fpga_cfg_pkg::DEF_CFG_HEIGHT
);
    logic                  start;
    logic                  bs_valid;
    logic [CFG_HEIGHT-1:0] bs_data;
    logic                  bs_ready;
    logic                  shift;
    logic [CFG_HEIGHT-1:0] cdata;
    logic                  busy;
    logic                  configured;
    logic                  done;
    logic                  cpu_pcpi_valid;
    logic                  fab_pcpi_valid;

    modport master (
        output start, bs_valid, bs_data, cpu_pcpi_valid,
        input  bs_ready, shift, cdata, busy, configured, done, fab_pcpi_valid
    );

    modport slave (
        input  start, bs_valid, bs_data, cpu_pcpi_valid,
        output bs_ready, shift, cdata, busy, configured, done, fab_pcpi_valid
    );
endinterface

// File: rtl/fabric_cfg_ctrl.sv
// Loads a CFG_LENGTH-column bitstream into the fabric chain and gates PCPI
// requests to the fabric until a complete configuration is present.
module fabric_cfg_ctrl
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned CFG_HEIGHT = DEF_CFG_HEIGHT,
    parameter int unsigned CFG_LENGTH = DEF_CFG_LENGTH
) (
    input  logic             clk,
    input  logic             rst,
    fabric_cfg_ctrl_if.slave bus
);

    localparam int unsigned      CNT_W     = $clog2(CFG_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CFG_LENGTH);

    cfg_state_e            state_q, state_d;
    logic                  pending_q, pending_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  shift_q, shift_d;
    logic [CFG_HEIGHT-1:0] cdata_q, cdata_d;
    logic                  configured_q, configured_d;
    logic                  done_q, done_d;
    logic                  accept_s;
    logic [CNT_W-1:0]      beat_num_s;

    assign accept_s   = (state_q == CFG_LOAD) && bus.bs_valid;
    assign beat_num_s = cnt_q + CNT_W'(1);

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        shift_d      = 1'b0;
        cdata_d      = cdata_q;
        configured_d = configured_q;
        done_d       = 1'b0;
        case (state_q)
            CFG_IDLE, CFG_WAIT: begin
                if (bus.start) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                // The fabric may only change once no PCPI transaction is open.
                if (pending_q && !bus.cpu_pcpi_valid) begin
                    state_d      = CFG_LOAD;
                    pending_d    = 1'b0;
                    configured_d = 1'b0;
                    cnt_d        = '0;
                end else if (pending_q) begin
                    state_d = CFG_WAIT;
                end else begin
                    state_d = state_q;
                end
            end
            CFG_LOAD: begin
                if (accept_s) begin
                    shift_d = 1'b1;
                    cdata_d = bus.bs_data;
                    cnt_d   = beat_num_s;
                    if (beat_num_s == LAST_BEAT) begin
                        state_d = CFG_FLUSH;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    shift_d = 1'b0;
                    cdata_d = cdata_q;
                end
            end
            CFG_FLUSH: begin
                configured_d = 1'b1;
                done_d       = 1'b1;
                state_d      = CFG_IDLE;
            end
            default: begin
                state_d = CFG_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CFG_IDLE;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= 1'b0;
            cdata_q      <= '0;
            configured_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            cdata_q      <= cdata_d;
            configured_q <= configured_d;
            done_q       <= done_d;
        end
    end

    assign bus.bs_ready       = (state_q == CFG_LOAD);
    assign bus.shift          = shift_q;
    assign bus.cdata          = cdata_q;
    assign bus.busy           = pending_q || (state_q != CFG_IDLE);
    assign bus.configured     = configured_q;
    assign bus.done           = done_q;
    assign bus.fab_pcpi_valid = bus.cpu_pcpi_valid && configured_q;

endmodule

// File: doc/fabric_cfg_ctrl.md
# fabric_cfg_ctrl

Configuration and access controller for the `fpga` fabric model. It accepts a bitstream as a valid/ready stream of `CFG_HEIGHT`-bit columns and drives the fabric's `shift`/`cdata` configuration chain for exactly `CFG_LENGTH` shift cycles. It tracks whether the fabric holds a complete configuration and forwards the CPU's PCPI requests to the fabric only while it does. A reconfiguration request is held off until no PCPI transaction is in flight.

## Interface
Parameters:
- `CFG_HEIGHT`, 32: width of one configuration column (`cdata`).
- `CFG_LENGTH`, 64: number of columns (shift cycles) in a full bitstream; must be ≥1.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to (re)load the fabric.
- `bs_valid` in 1: bitstream column valid.
- `bs_data` in `CFG_HEIGHT`: bitstream column.
- `bs_ready` out 1: column accepted when `bs_valid && bs_ready`.
- `shift` out 1: fabric chain shift enable (registered).
- `cdata` out `CFG_HEIGHT`: fabric chain data (registered).
- `busy` out 1: load pending or in progress.
- `configured` out 1: fabric holds a complete bitstream.
- `done` out 1: one-cycle pulse when a load completes.
- `cpu_pcpi_valid` in 1: PCPI valid from CPU.
- `fab_pcpi_valid` out 1: `cpu_pcpi_valid && configured` (combinational).

## Operation
- State machine with states IDLE, WAIT, LOAD, FLUSH.
- `start` sets an internal `pending` flag in any state except LOAD and FLUSH. In LOAD and FLUSH, `start` is ignored.
- IDLE:
  - If `pending` and `cpu_pcpi_valid`=0, go to LOAD. Clear `pending`, clear `configured`, reset the beat counter.
  - If `pending` and `cpu_pcpi_valid`=1, go to WAIT.
- WAIT: go to LOAD (same actions as above) on the first cycle with `cpu_pcpi_valid`=0.
- LOAD:
  - `bs_ready`=1.
  - On each accepted beat: register `cdata`←`bs_data`, `shift`←1, increment the beat counter.
  - In cycles with no accepted beat: `shift`←0 and `cdata` holds its value.
  - When the accepted beat is number `CFG_LENGTH`, go to FLUSH.
- FLUSH:
  - `bs_ready`=0 and `shift`←0.
  - Set `configured`←1 and pulse `done`, then go to IDLE.
- `bs_ready`=0 in every state except LOAD. Extra bitstream beats after the last one are not consumed.
- Beat counter width is `$clog2(CFG_LENGTH+1)`. The counter never wraps, because it is compared against `CFG_LENGTH`.
- `busy` = (`pending` || state≠IDLE).
- `configured` stays 0 from the start of any load until that load completes. While it is 0, PCPI requests are masked (no fabric response, so the CPU traps).
- Reset mid-load: go to IDLE with `configured`=0 and `pending`=0. A partial chain is not usable, and software must reload.

## Timing
- Reset values: state IDLE; `shift`=0, `cdata`=0, `busy`=0, `configured`=0, `done`=0, `bs_ready`=0.
- Beat accepted at edge N → `shift`=1 with that column on `cdata` during cycle N..N+1. The fabric captures it at edge N+1. Latency is one cycle.
- Uninterrupted load: `start` at edge S → LOAD from S+1 (when `cpu_pcpi_valid`=0 at S+1); last beat at S+1+`CFG_LENGTH`; FLUSH one cycle later; `configured`/`done` visible one cycle after FLUSH.
- `configured` falls one cycle after the IDLE/WAIT→LOAD decision. `fab_pcpi_valid` follows it combinationally.
- `start` and `cpu_pcpi_valid` high in the same cycle → WAIT. No fabric bit changes while a PCPI transaction is outstanding.
- `start` arriving during FLUSH is ignored. `start` arriving in IDLE after `done` starts a new load.

## Structure
- Package `fpga_cfg_pkg` holds:
  - The state enum (`CFG_IDLE`, `CFG_WAIT`, `CFG_LOAD`, `CFG_FLUSH`).
  - The default `CFG_HEIGHT`/`CFG_LENGTH` constants, shared with the fabric and benches.
- Single module; no sub-module. The beat counter and FSM are inline.

## Test plan
- Reset, then `start` with `CFG_LENGTH`=4 and continuous beats 0x1,0x2,0x3,0x4 → `shift` high for exactly 4 consecutive cycles with `cdata` 0x1..0x4, then `done`=1 for one cycle and `configured`=1.
- Same load with `bs_valid` toggling 1,0,1,0,… → `shift` asserted only in the 4 cycles after accepted beats, same `cdata` sequence.
- Configured fabric, `cpu_pcpi_valid`=1 held for 5 cycles, `start` pulsed in cycle 1 → state WAIT and `bs_ready`=0 until `cpu_pcpi_valid` drops; `configured` stays 1 and `fab_pcpi_valid`=1 throughout; LOAD begins the cycle after the drop.
- `cpu_pcpi_valid`=1 while `configured`=0 → `fab_pcpi_valid`=0.
- `rst` asserted after 2 of 4 beats → the following cycle shows `shift`=0, `configured`=0, `busy`=0, `bs_ready`=0. A full reload afterwards completes normally.
- `start` pulsed during LOAD and again during FLUSH → both ignored; `busy`=0 after `done`, and no second load starts.
